// File: rtl/dmni_br_receiver_pkg.sv
// Shared types and register map for the DMNI BrLite receive endpoint.
// Optional build macro used by the receiver: BR_RX_TIMESTAMP_EN.
package dmni_br_receiver_pkg;

  // BrLite broadcast message as delivered by the local router port.
  typedef struct packed {
    logic [15:0] payload;
    logic [15:0] seq_source;
    logic [3:0]  ksvc;
  } br_payload_t;

  localparam int BR_PAYLOAD_WIDTH = $bits(br_payload_t);
  localparam int BR_TS_WIDTH      = 32;

  // CPU-visible register offsets.
  typedef enum logic [7:0] {
    DMNI_BR_KSVC      = 8'h40,
    DMNI_BR_PAYLOAD   = 8'h44,
    DMNI_BR_STATUS    = 8'h48,
    DMNI_BR_TIMESTAMP = 8'h4C
  } dmni_mmr_t;

  // CPU view of a message body: sequence/source in the upper half.
  function automatic logic [31:0] br_payload_word(input br_payload_t msg);
    return {msg.seq_source, msg.payload};
  endfunction

endpackage

// File: rtl/dmni_br_fifo.sv
// Generic synchronous FIFO: DEPTH must be a power of two so the pointers
// wrap naturally. Flush wins over a same-cycle push or pop.
module dmni_br_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  // Push is refused when full, so a full FIFO with push+pop only pops.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Storage array, written at the tail; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmni_br_receiver.sv
// BrLite broadcast receive endpoint: buffers router messages and exposes
// the head to the CPU, with a level interrupt while messages are pending.
// Optional build macro: BR_RX_TIMESTAMP_EN adds a per-message acceptance
// timestamp readable at DMNI_BR_TIMESTAMP.
module dmni_br_receiver
  import dmni_br_receiver_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  br_req_i,
  output logic                  br_ack_o,
  input  logic [35:0]           br_data_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_we_i,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
  input  logic [31:0]           cfg_data_i,
  output logic [31:0]           cfg_data_o,
  output logic                  irq_o
);

  localparam int CW = $clog2(BUFFER_SIZE) + 1;
`ifdef BR_RX_TIMESTAMP_EN
  localparam int FW = BR_PAYLOAD_WIDTH + BR_TS_WIDTH;
`else
  localparam int FW = BR_PAYLOAD_WIDTH;
`endif

  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  br_payload_t   head_msg;
  logic          push;
  logic          pop;
  logic          flush;
  logic          rd_en;
  logic          status_wr;
  logic          irq_en;
  logic [31:0]   rd_data;
  logic          unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data_i[30:1];

  // Ack is also held low while reset is asserted so a router that keeps
  // requesting during reset never sees a phantom acceptance.
  assign br_ack_o = br_req_i & ~fifo_full & rst_ni;
  assign push     = br_req_i & br_ack_o;

  assign rd_en     = cfg_en_i & ~cfg_we_i;
  assign status_wr = cfg_en_i & cfg_we_i &
                     (cfg_addr_i == ADDR_WIDTH'(DMNI_BR_STATUS));
  assign flush     = status_wr & cfg_data_i[0];
  assign pop       = rd_en & ~fifo_empty &
                     (cfg_addr_i == ADDR_WIDTH'(DMNI_BR_PAYLOAD));

  assign head_msg = br_payload_t'(fifo_head[BR_PAYLOAD_WIDTH-1:0]);

`ifdef BR_RX_TIMESTAMP_EN
  logic [BR_TS_WIDTH-1:0] ts_cnt;

  // Free-running cycle counter sampled into each accepted entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 32'd1;
  end

  assign fifo_din = {ts_cnt, br_data_i};
`else
  assign fifo_din = br_data_i;
`endif

  dmni_br_fifo #(
    .DEPTH (BUFFER_SIZE),
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (fifo_din),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register read decode; an empty FIFO reads as zero.
  always_comb begin
    rd_data = '0;
    if (cfg_addr_i == ADDR_WIDTH'(DMNI_BR_KSVC)) begin
      if (!fifo_empty) rd_data = {28'b0, head_msg.ksvc};
    end else if (cfg_addr_i == ADDR_WIDTH'(DMNI_BR_PAYLOAD)) begin
      if (!fifo_empty) rd_data = br_payload_word(head_msg);
    end else if (cfg_addr_i == ADDR_WIDTH'(DMNI_BR_STATUS)) begin
      rd_data = {irq_en, 23'b0, 8'(fifo_count)};
`ifdef BR_RX_TIMESTAMP_EN
    end else if (cfg_addr_i == ADDR_WIDTH'(DMNI_BR_TIMESTAMP)) begin
      if (!fifo_empty) rd_data = fifo_head[FW-1:BR_PAYLOAD_WIDTH];
`endif
    end
  end

  // Read data register: captured on a read strobe, held otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cfg_data_o <= '0;
    else if (rd_en) cfg_data_o <= rd_data;
  end

  // Interrupt enable written through the status register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        irq_en <= 1'b0;
    else if (status_wr) irq_en <= cfg_data_i[31];
  end

  // Registered level interrupt while messages are pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_o <= 1'b0;
    else         irq_o <= irq_en & ~fifo_empty;
  end

endmodule
